// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam int         BREAK_BIT    = 8;
  localparam int         CODE_W       = BREAK_BIT + 1;

  // Odd parity check over the eight data bits plus the received parity bit.
  function automatic logic parity_ok(input logic [7:0] code, input logic par);
    return ^{code, par};
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - scan-code read port and status of the PS/2 receiver
interface ps2_kbd_rx_if #(
  parameter int FIFO_DEPTH = 8
);
  logic                          iRead;
  logic [8:0]                    oData;
  logic                          oValid;
  logic [$clog2(FIFO_DEPTH):0]   oCount;
  logic                          oParityErr;
  logic                          oFrameErr;
  logic                          oOverflow;

  modport master (
    input  iRead,
    output oData, oValid, oCount, oParityErr, oFrameErr, oOverflow
  );

  modport slave (
    output iRead,
    input  oData, oValid, oCount, oParityErr, oFrameErr, oOverflow
  );
endinterface

// File: rtl/ps2_sync_fifo.sv
// rtl/ps2_sync_fifo.sv - synchronous FIFO with sticky overflow and zeroed empty head
module ps2_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_rd, do_wr, full;

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    do_rd      = rd_en_i && (count_q != '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    do_wr      = wr_en_i && (!full || do_rd);
    wr_ptr_d   = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(do_wr) - CW'(do_rd);
    overflow_d = overflow_q || (wr_en_i && full && !do_rd);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign valid_o    = (count_q != '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard frame receiver feeding a scan-code FIFO
// Optional break-prefix folding into bit 8 when PS2_BREAK_FILTER_EN is defined.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          PS2_CLK,
  input  logic          PS2_DATA,
  ps2_kbd_rx_if.master  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  ps2_state_e             state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   parity_ok_q;
  logic [TW-1:0]          tmo_q;
  logic                   parity_err_q, frame_err_q, wr_en_q;
  logic [CODE_W-1:0]      wr_data_q;
`ifdef PS2_BREAK_FILTER_EN
  logic                   brk_q;
`endif

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q && !clk_s;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], PS2_DATA};
      clk_prev_q  <= clk_s;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_ok_q  <= 1'b0;
      tmo_q        <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
`ifdef PS2_BREAK_FILTER_EN
      brk_q        <= 1'b0;
`endif
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!data_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_ok_q <= parity_ok(shift_q, data_s);
            state_q     <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (!data_s || !parity_ok_q) begin
              frame_err_q  <= !data_s;
              parity_err_q <= data_s;
`ifdef PS2_BREAK_FILTER_EN
              brk_q        <= 1'b0;
`endif
            end else begin
`ifdef PS2_BREAK_FILTER_EN
              if (shift_q == BREAK_PREFIX) begin
                brk_q <= 1'b1;
              end else begin
                wr_en_q   <= 1'b1;
                wr_data_q <= {brk_q, shift_q};
                brk_q     <= 1'b0;
              end
`else
              wr_en_q   <= 1'b1;
              wr_data_q <= {1'b0, shift_q};
`endif
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        // A keyboard that stops clocking mid-frame must not wedge the receiver.
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q     <= ST_IDLE;
          frame_err_q <= 1'b1;
          tmo_q       <= '0;
`ifdef PS2_BREAK_FILTER_EN
          brk_q       <= 1'b0;
`endif
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  ps2_sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (Clock),
    .rst_ni     (Reset),
    .wr_en_i    (wr_en_q),
    .wr_data_i  (wr_data_q),
    .rd_en_i    (bus.iRead),
    .rd_data_o  (bus.oData),
    .valid_o    (bus.oValid),
    .count_o    (bus.oCount),
    .overflow_o (bus.oOverflow)
  );

  assign bus.oParityErr = parity_err_q;
  assign bus.oFrameErr  = frame_err_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed self-checking bench for ps2_kbd_rx
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 10;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic PS2_CLK = 1'b1;
  logic PS2_DATA = 1'b1;

  int n_checks = 0;
  int n_fail = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int perr0, ferr0;

  ps2_kbd_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_kbd_rx #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .bus      (bus.master)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (bus.oParityErr) perr_cnt <= perr_cnt + 1;
    if (bus.oFrameErr)  ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of a start/data/parity/stop frame, keyboard-style.
  task automatic send_bits(input logic [7:0] code, input logic par, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = f[i];
      repeat (HALF) @(posedge Clock);
      PS2_CLK = 1'b0;
      repeat (HALF) @(posedge Clock);
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
    repeat (8) @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic send_good(input logic [7:0] code, input logic par);
    send_bits(code, par, 1'b1, 11);
  endtask

  task automatic pop();
    @(negedge Clock);
    bus.iRead = 1'b1;
    @(negedge Clock);
    bus.iRead = 1'b0;
  endtask

  initial begin
    bus.iRead = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_valid", 32'(bus.oValid), 32'd0);
    check("rst_count", 32'(bus.oCount), 32'd0);
    check("rst_data", 32'(bus.oData), 32'h000);
    check("rst_ovf", 32'(bus.oOverflow), 32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);

    send_good(8'h1C, 1'b0);
    check("good_valid", 32'(bus.oValid), 32'd1);
    check("good_data", 32'(bus.oData), 32'h01C);
    check("good_count", 32'(bus.oCount), 32'd1);
    pop();
    check("pop_valid", 32'(bus.oValid), 32'd0);
    pop();
    check("pop_empty_count", 32'(bus.oCount), 32'd0);

    perr0 = perr_cnt;
    send_good(8'h1C, 1'b1);
    check("parity_pulse", 32'(perr_cnt - perr0), 32'd1);
    check("parity_nowrite", 32'(bus.oCount), 32'd0);

    ferr0 = ferr_cnt;
    send_bits(8'h1C, 1'b0, 1'b0, 11);
    check("stop_pulse", 32'(ferr_cnt - ferr0), 32'd1);
    check("stop_nowrite", 32'(bus.oCount), 32'd0);

    send_good(8'hF0, 1'b1);
    send_good(8'h1C, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
    check("brk_count", 32'(bus.oCount), 32'd1);
    check("brk_data", 32'(bus.oData), 32'h11C);
    pop();
`else
    check("brk_count", 32'(bus.oCount), 32'd2);
    check("brk_data0", 32'(bus.oData), 32'h0F0);
    pop();
    check("brk_data1", 32'(bus.oData), 32'h01C);
    pop();
`endif
    check("brk_empty", 32'(bus.oValid), 32'd0);

    send_good(8'h1C, 1'b0);
    send_good(8'h32, 1'b0);
    send_good(8'h21, 1'b1);
    send_good(8'h23, 1'b0);
    check("full_ovf_before", 32'(bus.oOverflow), 32'd0);
    send_good(8'h2B, 1'b1);
    check("full_count", 32'(bus.oCount), 32'd4);
    check("full_ovf", 32'(bus.oOverflow), 32'd1);
    check("full_e0", 32'(bus.oData), 32'h01C);
    pop();
    check("full_e1", 32'(bus.oData), 32'h032);
    pop();
    check("full_e2", 32'(bus.oData), 32'h021);
    pop();
    check("full_e3", 32'(bus.oData), 32'h023);
    pop();
    check("full_drained", 32'(bus.oValid), 32'd0);
    check("full_data_empty", 32'(bus.oData), 32'h000);

    ferr0 = ferr_cnt;
    send_bits(8'h55, 1'b1, 1'b1, 5);
    check("tmo_nopulse_yet", 32'(ferr_cnt - ferr0), 32'd0);
    repeat (TIMEOUT + 2) @(negedge Clock);
    check("tmo_pulse", 32'(ferr_cnt - ferr0), 32'd1);
    check("tmo_idle", 32'(dut.state_q), 32'(ST_IDLE));
    send_good(8'h32, 1'b0);
    check("tmo_recover", 32'(bus.oData), 32'h032);
    check("tmo_count", 32'(bus.oCount), 32'd1);

    send_bits(8'h77, 1'b1, 1'b1, 6);
    Reset = 1'b0;
    @(negedge Clock);
    check("mrst_valid", 32'(bus.oValid), 32'd0);
    check("mrst_count", 32'(bus.oCount), 32'd0);
    check("mrst_data", 32'(bus.oData), 32'h000);
    check("mrst_ovf", 32'(bus.oOverflow), 32'd0);
    check("mrst_perr", 32'(bus.oParityErr), 32'd0);
    check("mrst_ferr", 32'(bus.oFrameErr), 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    send_good(8'h1C, 1'b0);
    check("mrst_rx_data", 32'(bus.oData), 32'h01C);
    check("mrst_rx_count", 32'(bus.oCount), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
